multi_edge_detector: RTL and testbench
======================================

Name: multi_edge_detector

Overview:
- Parametrised multi-channel successor to the single-bit rising-edge detector.
- Per channel: resynchronises an asynchronous input and debounces it with a stability filter.
- Detects rising, falling or both edges, selected per channel at runtime.
- Outputs a one-cycle registered pulse, a sticky status flag and a saturating edge counter; sits between raw pins/cross-domain strobes and interrupt/status logic.

Parameters:
- WIDTH, 8, number of independent channels (>=1)
- SYNC_STAGES, 2, synchroniser flops per channel (>=2)
- FILTER_LEN, 4, consecutive cycles a new level must hold before acceptance (>=1)
- CNT_W, 8, per-channel edge-counter width (>=1)
- RESET_LEVEL, 1'b0, value loaded into synchroniser and filtered level at reset

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- d  input  WIDTH  raw channel inputs, may be asynchronous
- mode  input  2*WIDTH  per-channel select, channel i uses mode[2i+1:2i]
- clr  input  WIDTH  per-channel sticky-flag clear
- cnt_clr  input  WIDTH  per-channel counter clear
- pulse  output  WIDTH  one-cycle edge pulse per channel
- any_pulse  output  1  OR of all pulse bits, same cycle
- status  output  WIDTH  sticky edge flags
- count  output  CNT_W*WIDTH  per-channel saturating edge counts, channel i at [CNT_W*(i+1)-1:CNT_W*i]

Behaviour:
- Reset (async assert; release synchronous to clk by the integrator):
  - sync chain and filtered level = RESET_LEVEL; filter counters = 0.
  - pulse = 0, any_pulse = 0, status = 0, count = 0.
- No edge is reported after reset release unless d differs from RESET_LEVEL and passes the filter. Reset mid-filter discards the partial count.
- Sync: chain of SYNC_STAGES flops; s = last stage.
- Filter, per channel: level f, counter fc, width clog2(FILTER_LEN+1).
  - s == f: fc <= 0.
  - s != f and fc == FILTER_LEN-1: f <= s, fc <= 0, edge accepted.
  - Otherwise fc <= fc+1.
  - Glitches shorter than FILTER_LEN cycles at s produce no edge.
  - FILTER_LEN=1: f follows s one cycle later.
- Mode encoding: 00 off, 01 rise, 10 fall, 11 both.
  - An accepted edge qualifies if its direction matches the current-cycle mode.
  - mode is sampled only in the acceptance cycle.
  - Changing mode never creates a pulse by itself.
  - f keeps tracking s in mode 00.
- pulse[i] is registered and high for exactly one cycle, in the cycle after the accepting edge.
- Latency: new level stable at d before edge 1 → pulse high after edge SYNC_STAGES+FILTER_LEN (defaults: 6).
- Back-to-back qualifying edges are possible only as far as the filter allows: minimum spacing FILTER_LEN cycles.
- any_pulse is registered together with pulse, identical timing.
- status[i]: set on the edge that sets pulse[i]; cleared by clr[i]. Simultaneous set and clear → set wins (status stays 1).
- count[i]: increments on the edge that sets pulse[i] and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr[i] → 0.
  - Simultaneous clear and qualifying edge → 1.
- Channels are fully independent; simultaneous edges on all channels are each reported.
- Widths: all counters are unsigned; no truncation warnings; parameter checks via elaboration-time assertion (SYNC_STAGES>=2, FILTER_LEN>=1).

Decomposition:
- Package edge_det_pkg:
  - mode constants MODE_OFF/MODE_RISE/MODE_FALL/MODE_BOTH and a 2-bit edge_mode_t typedef.
  - clog2 helper for the filter counter width.
- One sub-module, edge_det_chan: single channel (sync, filter, qualify, status, counter), instantiated WIDTH times by generate.
- The top level adds only any_pulse and bus packing.

Test Plan:
- Reset, then d=0 held, mode=01 → no pulse for 20 cycles; status=0, count=0; async rst asserted mid-cycle clears all outputs immediately.
- ch0 mode=01, d[0] 0→1 held → pulse[0] high exactly one cycle after edge 6 (defaults); any_pulse same cycle; status[0]=1, count[0]=1; the later 1→0 gives no pulse.
- ch1 mode=11, d[1] glitch high for 3 cycles, then high for 10 cycles, then low for 10 → glitch ignored; two pulses; count[1]=2.
- ch2 mode=10, clr[2] and a qualifying fall accepted the same cycle → status[2] stays 1; cnt_clr[2] with a simultaneous edge → count[2]=1.
- CNT_W=2, 5 rising edges on ch3 → count[3] = 1,2,3,3,3 (saturates); mode switched 01→00 between edges 2 and 3 → those edges are not counted and the switch itself gives no pulse.
- All 8 channels toggle 0→1 in the same cycle with mode=01 → pulse=8'hFF for one cycle; status=8'hFF; each count=1.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
// Mode encoding selects which accepted filter transitions produce a pulse.
package edge_det_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One channel: synchroniser, stability filter, direction qualify,
// registered pulse, sticky status and saturating edge counter.
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 4,
  parameter int   CNT_W       = 8,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             d_i,
  input  edge_mode_t       mode_i,
  input  logic             clr_i,
  input  logic             cnt_clr_i,
  output logic             edge_o,
  output logic             pulse_o,
  output logic             status_o,
  output logic [CNT_W-1:0] count_o
);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("edge_det_chan: SYNC_STAGES must be >= 2");
  end
  if (FILTER_LEN < 1) begin : g_chk_filter
    $error("edge_det_chan: FILTER_LEN must be >= 1");
  end

  localparam int               FC_W    = clog2(FILTER_LEN + 1);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lvl_q, lvl_d;
  logic [FC_W-1:0]        fc_q, fc_d;
  logic                   pulse_q, pulse_d;
  logic                   status_q, status_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sync_lvl;
  logic                   accept;
  logic                   qualify;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], d_i};
    sync_lvl = sync_q[SYNC_STAGES-1];
    lvl_d    = lvl_q;
    fc_d     = '0;
    accept   = 1'b0;

    // The filter counter only runs while the synchronised level disagrees.
    if (sync_lvl != lvl_q) begin
      if (fc_q == FC_LAST) begin
        lvl_d  = sync_lvl;
        accept = 1'b1;
      end else begin
        fc_d = fc_q + FC_W'(1);
      end
    end

    case (mode_i)
      MODE_RISE: qualify = accept & sync_lvl;
      MODE_FALL: qualify = accept & ~sync_lvl;
      MODE_BOTH: qualify = accept;
      default:   qualify = 1'b0;
    endcase

    pulse_d  = qualify;
    status_d = qualify | (status_q & ~clr_i);

    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = qualify ? CNT_W'(1) : '0;
    end else if (qualify && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= {SYNC_STAGES{RESET_LEVEL}};
      lvl_q    <= RESET_LEVEL;
      fc_q     <= '0;
      pulse_q  <= 1'b0;
      status_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      lvl_q    <= lvl_d;
      fc_q     <= fc_d;
      pulse_q  <= pulse_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
    end
  end

  assign edge_o   = qualify;
  assign pulse_o  = pulse_q;
  assign status_o = status_q;
  assign count_o  = cnt_q;

endmodule

// File: rtl/multi_edge_detector.sv
// WIDTH independent edge-detect channels with packed buses and a
// registered any-pulse flag aligned with the per-channel pulses.
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int   WIDTH       = 8,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 4,
  parameter int   CNT_W       = 8,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [WIDTH-1:0]       d_i,
  input  logic [2*WIDTH-1:0]     mode_i,
  input  logic [WIDTH-1:0]       clr_i,
  input  logic [WIDTH-1:0]       cnt_clr_i,
  output logic [WIDTH-1:0]       pulse_o,
  output logic                   any_pulse_o,
  output logic [WIDTH-1:0]       status_o,
  output logic [CNT_W*WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] edge_vec;
  logic             any_q, any_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .CNT_W       (CNT_W),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .d_i       (d_i[i]),
      .mode_i    (edge_mode_t'(mode_i[2*i +: 2])),
      .clr_i     (clr_i[i]),
      .cnt_clr_i (cnt_clr_i[i]),
      .edge_o    (edge_vec[i]),
      .pulse_o   (pulse_o[i]),
      .status_o  (status_o[i]),
      .count_o   (count_o[CNT_W*i +: CNT_W])
    );
  end

  // Built from the pre-register qualify terms so it lands with pulse_o.
  assign any_d = |edge_vec;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      any_q <= 1'b0;
    end else begin
      any_q <= any_d;
    end
  end

  assign any_pulse_o = any_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench: stimulus pushes expected pulse events, a monitor pops
// and compares them whenever the DUT raises a pulse.
module tb_multi_edge_detector;

  localparam int W  = 8;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    d;
  logic [2*W-1:0]  mode;
  logic [W-1:0]    clr;
  logic [W-1:0]    cnt_clr;
  logic [W-1:0]    pulse_o;
  logic            any_pulse_o;
  logic [W-1:0]    status_o;
  logic [CW*W-1:0] count_o;

  multi_edge_detector #(
    .WIDTH(W), .SYNC_STAGES(2), .FILTER_LEN(4), .CNT_W(CW), .RESET_LEVEL(1'b0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .d_i(d), .mode_i(mode), .clr_i(clr),
    .cnt_clr_i(cnt_clr), .pulse_o(pulse_o), .any_pulse_o(any_pulse_o),
    .status_o(status_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              at;
    logic [W-1:0]    pulse;
    logic [W-1:0]    status;
    logic [CW*W-1:0] count;
  } exp_t;

  exp_t         q[$];
  exp_t         e;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_st;
  int           exp_cnt[W];
  int           t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [CW*W-1:0] pack_cnt();
    logic [CW*W-1:0] v;
    for (int i = 0; i < W; i++) v[CW*i +: CW] = exp_cnt[i][CW-1:0];
    return v;
  endfunction

  task automatic push(input int at, input logic [W-1:0] p);
    exp_t x;
    x.at = at; x.pulse = p; x.status = exp_st; x.count = pack_cnt();
    q.push_back(x);
  endtask

  task automatic drain(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_pulse: %0d expected pulses never seen, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rise3(input bit counted, input int new_cnt);
    d[3] = 1'b1;
    t = cyc;
    if (counted) begin
      exp_st[3]  = 1'b1;
      exp_cnt[3] = new_cnt;
      push(t + 6, 8'h08);
    end
    wait_n(8);
    d[3] = 1'b0;
    wait_n(8);
  endtask

  always @(negedge clk) begin
    if (!rst && (pulse_o != '0 || any_pulse_o)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: pulse=%0h any=%0b at cycle %0d, required no pulse",
                 pulse_o, any_pulse_o, cyc);
      end else begin
        e = q.pop_front();
        chk("pulse_cycle", 32'(cyc), 32'(e.at));
        chk("pulse_vec", 32'(pulse_o), 32'(e.pulse));
        chk("any_pulse", 32'(any_pulse_o), 32'(e.pulse != '0));
        chk("status_at_pulse", 32'(status_o), 32'(e.status));
        chk("count_at_pulse", 32'(count_o), 32'(e.count));
      end
    end
  end

  initial begin
    rst = 1'b1; d = '0; mode = 16'h5555; clr = '0; cnt_clr = '0;
    exp_st = '0;
    for (int i = 0; i < W; i++) exp_cnt[i] = 0;

    wait_n(3);
    chk("reset_pulse", 32'(pulse_o), 0);
    chk("reset_any", 32'(any_pulse_o), 0);
    chk("reset_status", 32'(status_o), 0);
    chk("reset_count", 32'(count_o), 0);
    rst = 1'b0;

    wait_n(20);
    chk("idle_status", 32'(status_o), 0);
    chk("idle_count", 32'(count_o), 0);
    drain("idle");

    // ch0 rising edge; later fall ignored in rise mode
    d[0] = 1'b1; t = cyc;
    exp_st[0] = 1'b1; exp_cnt[0] = 1;
    push(t + 6, 8'h01);
    wait_n(12);
    d[0] = 1'b0;
    wait_n(12);
    drain("ch0");
    chk("ch0_status", 32'(status_o), 32'h01);

    // asynchronous reset in mid-cycle
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pulse", 32'(pulse_o), 0);
    chk("async_rst_any", 32'(any_pulse_o), 0);
    chk("async_rst_status", 32'(status_o), 0);
    chk("async_rst_count", 32'(count_o), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_st = '0;
    for (int i = 0; i < W; i++) exp_cnt[i] = 0;
    wait_n(4);

    // ch1 both edges, short glitch rejected
    mode[3:2] = 2'b11;
    d[1] = 1'b1;
    wait_n(3);
    d[1] = 1'b0;
    wait_n(8);
    d[1] = 1'b1; t = cyc;
    exp_st[1] = 1'b1; exp_cnt[1] = 1;
    push(t + 6, 8'h02);
    wait_n(10);
    d[1] = 1'b0; t = cyc;
    exp_cnt[1] = 2;
    push(t + 6, 8'h02);
    wait_n(12);
    drain("ch1");
    chk("ch1_count", 32'(count_o[3:2]), 2);

    // ch2 fall mode: clear and edge in the same cycle
    mode[5:4] = 2'b10;
    d[2] = 1'b1;
    wait_n(10);
    d[2] = 1'b0; t = cyc;
    wait_n(5);
    clr[2] = 1'b1;
    exp_st[2] = 1'b1; exp_cnt[2] = 1;
    push(t + 6, 8'h04);
    wait_n(1);
    clr[2] = 1'b0;
    wait_n(6);
    drain("ch2_clr");
    clr[2] = 1'b1;
    wait_n(1);
    clr[2] = 1'b0;
    exp_st[2] = 1'b0;
    chk("ch2_clr_alone", 32'(status_o), 32'(exp_st));
    d[2] = 1'b1;
    wait_n(10);
    d[2] = 1'b0; t = cyc;
    wait_n(5);
    cnt_clr[2] = 1'b1;
    exp_st[2] = 1'b1; exp_cnt[2] = 1;
    push(t + 6, 8'h04);
    wait_n(1);
    cnt_clr[2] = 1'b0;
    wait_n(8);
    drain("ch2_cnt_clr");
    chk("ch2_count", 32'(count_o[5:4]), 1);

    // ch3 saturation with a mode-off window
    rise3(1, 1);
    rise3(1, 2);
    mode[7:6] = 2'b00;
    wait_n(4);
    rise3(0, 0);
    rise3(0, 0);
    chk("ch3_count_off", 32'(count_o[7:6]), 2);
    mode[7:6] = 2'b01;
    wait_n(8);
    rise3(1, 3);
    rise3(1, 3);
    rise3(1, 3);
    drain("ch3");
    chk("ch3_count_sat", 32'(count_o[7:6]), 3);

    // all channels at once
    mode = 16'h5555;
    clr = '1; cnt_clr = '1;
    wait_n(1);
    clr = '0; cnt_clr = '0;
    exp_st = '0;
    for (int i = 0; i < W; i++) exp_cnt[i] = 0;
    chk("all_cleared_status", 32'(status_o), 0);
    chk("all_cleared_count", 32'(count_o), 0);
    d = '1; t = cyc;
    exp_st = '1;
    for (int i = 0; i < W; i++) exp_cnt[i] = 1;
    push(t + 6, 8'hFF);
    wait_n(10);
    drain("all");
    chk("all_status", 32'(status_o), 32'hFF);
    chk("all_count", 32'(count_o), 32'h5555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
